mmv_input_packer: RTL and testbench

//  Upstream feeder for the MMV sliding-window unit. Packs MMV consecutive SIMD-wide pixel/channel beats into one
//  MMV*SIMD*IP_PRECISION word, which is the write width of the window unit's asymmetric buffer.

---
 rtl/mmv_input_packer.sv | 130 +++++++++++++
 tb/tb_mmv_input_packer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmv_input_packer.sv
// Packs MMV consecutive SIMD-wide input beats into one wide word for the MMV window buffer.
// A frame that ends mid-word emits a zero-padded final word flagged with tlast.
module mmv_input_packer #(
    parameter int SIMD         = 1,
    parameter int IP_PRECISION = 8,
    parameter int MMV          = 2,
    parameter int IFMChannels  = 2,
    parameter int IFMWidth     = 8,
    parameter int IFMHeight    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [SIMD*IP_PRECISION-1:0]     ip_axis_tdata,
    input  logic                             ip_axis_tvalid,
    output logic                             ip_axis_tready,
    output logic [MMV*SIMD*IP_PRECISION-1:0] op_axis_tdata,
    output logic                             op_axis_tvalid,
    input  logic                             op_axis_tready,
    output logic                             op_axis_tlast
);

    localparam int W           = SIMD * IP_PRECISION;
    localparam int FRAME_BEATS = IFMHeight * IFMWidth * IFMChannels / SIMD;
    localparam int LANE_W      = (MMV > 1) ? $clog2(MMV) : 1;
    localparam int BEAT_W      = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int COLL_N      = (MMV > 1) ? MMV - 1 : 1;
    localparam int COLL_BITS   = COLL_N * W;
    localparam int WORD_BITS   = MMV * W;

    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [COLL_BITS-1:0] coll_q, coll_d;
    logic [WORD_BITS-1:0] odata_q, odata_d;
    logic                 ovld_q, ovld_d;
    logic                 olast_q, olast_d;

    logic last_lane, last_beat, completing, in_ready, in_fire, out_fire;

    // Builds the output word: collected lanes below the current one, the incoming beat
    // at the current lane, and zeros above it (stale collector lanes must not leak).
    function automatic logic [WORD_BITS-1:0] pack_word(
        input logic [COLL_BITS-1:0] coll,
        input logic [W-1:0]         beat,
        input logic [LANE_W-1:0]    lane
    );
        logic [WORD_BITS-1:0] word;
        logic [WORD_BITS-1:0] ext;
        word = '0;
        for (int k = 0; k < COLL_N; k++) begin
            if (k < int'(lane)) begin
                word[k*W +: W] = coll[k*W +: W];
            end
        end
        ext  = WORD_BITS'(beat);
        word = word | (ext << (int'(lane) * W));
        return word;
    endfunction

    function automatic logic [COLL_BITS-1:0] store_lane(
        input logic [COLL_BITS-1:0] coll,
        input logic [W-1:0]         beat,
        input logic [LANE_W-1:0]    lane
    );
        logic [COLL_BITS-1:0] mask;
        logic [COLL_BITS-1:0] ext;
        mask = COLL_BITS'({W{1'b1}});
        ext  = COLL_BITS'(beat);
        return (coll & ~(mask << (int'(lane) * W))) | (ext << (int'(lane) * W));
    endfunction

    assign last_lane  = (lane_q == LANE_W'(MMV - 1));
    assign last_beat  = (beat_cnt_q == BEAT_W'(FRAME_BEATS - 1));
    assign completing = last_lane || last_beat;

    // Only a completing beat needs the output register; it waits when that register is
    // full and not draining. Independent of ip_axis_tvalid by construction.
    assign in_ready = !(completing && ovld_q && !op_axis_tready);
    assign in_fire  = ip_axis_tvalid && in_ready;
    assign out_fire = ovld_q && op_axis_tready;

    always_comb begin
        lane_d     = lane_q;
        beat_cnt_d = beat_cnt_q;
        coll_d     = coll_q;
        odata_d    = odata_q;
        ovld_d     = ovld_q;
        olast_d    = olast_q;
        if (out_fire) begin
            ovld_d = 1'b0;
        end
        if (in_fire) begin
            if (completing) begin
                odata_d    = pack_word(coll_q, ip_axis_tdata, lane_q);
                olast_d    = last_beat;
                ovld_d     = 1'b1;
                lane_d     = '0;
                beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
            end else begin
                coll_d     = store_lane(coll_q, ip_axis_tdata, lane_q);
                lane_d     = lane_q + LANE_W'(1);
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    // Collect / output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q     <= '0;
            beat_cnt_q <= '0;
            coll_q     <= '0;
            odata_q    <= '0;
            ovld_q     <= 1'b0;
            olast_q    <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            beat_cnt_q <= beat_cnt_d;
            coll_q     <= coll_d;
            odata_q    <= odata_d;
            ovld_q     <= ovld_d;
            olast_q    <= olast_d;
        end
    end

    assign ip_axis_tready = in_ready;
    assign op_axis_tdata  = odata_q;
    assign op_axis_tvalid = ovld_q;
    assign op_axis_tlast  = olast_q;

endmodule

// File: tb/tb_mmv_input_packer.sv
// Scoreboard bench for mmv_input_packer: three configurations driven with directed and
// random beats, checked against a frame/word packing model kept in the bench.
module tb_mmv_input_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // u0: MMV=2 SIMD=1 PREC=8 3x3x1 ; u1: MMV=4 same frame ; u2: MMV=3 SIMD=2 PREC=4 2x2x2
    logic [7:0]  u0_id = '0; logic u0_iv = 1'b0; logic u0_ir;
    logic [15:0] u0_od;      logic u0_ov; logic u0_or = 1'b1; logic u0_ol;
    logic [7:0]  u1_id = '0; logic u1_iv = 1'b0; logic u1_ir;
    logic [31:0] u1_od;      logic u1_ov; logic u1_or = 1'b1; logic u1_ol;
    logic [7:0]  u2_id = '0; logic u2_iv = 1'b0; logic u2_ir;
    logic [23:0] u2_od;      logic u2_ov; logic u2_or = 1'b1; logic u2_ol;

    mmv_input_packer #(.SIMD(1), .IP_PRECISION(8), .MMV(2), .IFMChannels(1), .IFMWidth(3), .IFMHeight(3)) u0 (
        .clk(clk), .reset(reset),
        .ip_axis_tdata(u0_id), .ip_axis_tvalid(u0_iv), .ip_axis_tready(u0_ir),
        .op_axis_tdata(u0_od), .op_axis_tvalid(u0_ov), .op_axis_tready(u0_or), .op_axis_tlast(u0_ol));
    mmv_input_packer #(.SIMD(1), .IP_PRECISION(8), .MMV(4), .IFMChannels(1), .IFMWidth(3), .IFMHeight(3)) u1 (
        .clk(clk), .reset(reset),
        .ip_axis_tdata(u1_id), .ip_axis_tvalid(u1_iv), .ip_axis_tready(u1_ir),
        .op_axis_tdata(u1_od), .op_axis_tvalid(u1_ov), .op_axis_tready(u1_or), .op_axis_tlast(u1_ol));
    mmv_input_packer #(.SIMD(2), .IP_PRECISION(4), .MMV(3), .IFMChannels(2), .IFMWidth(2), .IFMHeight(2)) u2 (
        .clk(clk), .reset(reset),
        .ip_axis_tdata(u2_id), .ip_axis_tvalid(u2_iv), .ip_axis_tready(u2_ir),
        .op_axis_tdata(u2_od), .op_axis_tvalid(u2_ov), .op_axis_tready(u2_or), .op_axis_tlast(u2_ol));

    int tests = 0;
    int fails = 0;

    logic       rst_v;
    logic       iv[3];
    logic       ordy[3];
    logic       acc[3];
    logic [7:0] idat[3];
    int         stalls[3];

    // reference model: beats waiting for the current word, position in frame
    logic [63:0] pend_w[3];
    int          pend_n[3];
    int          fpos[3];
    logic [64:0] eq0[$], eq1[$], eq2[$];
    logic [64:0] ob0[$], ob1[$], ob2[$];
    logic        held_v[3];
    logic [64:0] held_w[3];

    function automatic int mmv_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 4 : 3;
    endfunction

    function automatic int fb_of(input int d);
        return (d == 2) ? 4 : 9;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? eq0.size() : (d == 1) ? eq1.size() : eq2.size();
    endfunction

    task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            pend_w[d] = '0; pend_n[d] = 0; fpos[d] = 0; held_v[d] = 1'b0;
        end
        eq0.delete(); eq1.delete(); eq2.delete();
    endtask

    task automatic model_beat(input int d, input logic [7:0] b);
        logic [64:0] w;
        pend_w[d] = pend_w[d] | (64'(b) << (8 * pend_n[d]));
        pend_n[d]++;
        fpos[d]++;
        if (pend_n[d] == mmv_of(d) || fpos[d] == fb_of(d)) begin
            w = {(fpos[d] == fb_of(d)), pend_w[d]};
            case (d)
                0: eq0.push_back(w);
                1: eq1.push_back(w);
                default: eq2.push_back(w);
            endcase
            pend_w[d] = '0;
            pend_n[d] = 0;
            if (fpos[d] == fb_of(d)) fpos[d] = 0;
        end
    endtask

    task automatic cycle();
        logic ir[3];
        logic comp, held;
        @(negedge clk);
        reset = rst_v;
        u0_iv = iv[0]; u0_id = idat[0]; u0_or = ordy[0];
        u1_iv = iv[1]; u1_id = idat[1]; u1_or = ordy[1];
        u2_iv = iv[2]; u2_id = idat[2]; u2_or = ordy[2];
        #1;
        ir[0] = u0_ir; ir[1] = u1_ir; ir[2] = u2_ir;
        for (int d = 0; d < 3; d++) begin
            acc[d] = 1'b0;
            if (!rst_v) begin
                comp = (pend_n[d] == mmv_of(d) - 1) || (fpos[d] == fb_of(d) - 1);
                held = qsize(d) > 0;
                check($sformatf("ip_tready_dut%0d", d), 65'(ir[d]), 65'(!(comp && held && !ordy[d])));
                acc[d] = iv[d] && ir[d];
                if (iv[d] && !ir[d]) stalls[d]++;
                if (acc[d]) model_beat(d, idat[d]);
            end
        end
        if (rst_v) model_clear();
    endtask

    task automatic mon(input int d, input logic ov, input logic rd, input logic [63:0] od, input logic ol);
        logic [64:0] e;
        if (held_v[d]) begin
            check($sformatf("hold_valid_dut%0d", d), 65'(ov), 65'(1));
            check($sformatf("hold_word_dut%0d", d), {ol, od}, held_w[d]);
        end
        held_v[d] = ov && !rd;
        held_w[d] = {ol, od};
        if (ov && rd) begin
            case (d)
                0: ob0.push_back({ol, od});
                1: ob1.push_back({ol, od});
                default: ob2.push_back({ol, od});
            endcase
            if (qsize(d) == 0) begin
                check($sformatf("unexpected_word_dut%0d", d), {ol, od}, 65'h0_dead_beef);
            end else begin
                case (d)
                    0: e = eq0.pop_front();
                    1: e = eq1.pop_front();
                    default: e = eq2.pop_front();
                endcase
                check($sformatf("word_dut%0d", d), {ol, od}, e);
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!reset) begin
            mon(0, u0_ov, u0_or, 64'(u0_od), u0_ol);
            mon(1, u1_ov, u1_or, 64'(u1_od), u1_ol);
            mon(2, u2_ov, u2_or, 64'(u2_od), u2_ol);
        end
    end

    task automatic idle(input int n);
        for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; ordy[d] = 1'b1; end
        repeat (n) cycle();
    endtask

    // mode 0: stream; 1: stream with 6-cycle output stall; 2: random valid, toggling ready;
    // 3: random valid and ready; 4: stream with output blocked
    task automatic run(input int d, input int n, input int mode, input logic [7:0] base);
        int k = 0;
        int c = 0;
        logic [7:0] cur;
        cur = (mode >= 2 && mode <= 3) ? 8'($urandom) : base;
        while (k < n && c < 40 * n + 100) begin
            case (mode)
                0: begin iv[d] = 1'b1; ordy[d] = 1'b1; end
                1: begin iv[d] = 1'b1; ordy[d] = !(c >= 3 && c < 9); end
                2: begin iv[d] = 1'($urandom % 2); ordy[d] = c[0]; end
                3: begin iv[d] = ($urandom_range(0, 3) != 0); ordy[d] = ($urandom_range(0, 3) != 0); end
                default: begin iv[d] = 1'b1; ordy[d] = 1'b0; end
            endcase
            idat[d] = cur;
            cycle();
            c++;
            if (acc[d]) begin
                k++;
                cur = (mode >= 2 && mode <= 3) ? 8'($urandom) : base + 8'(k);
            end
        end
        iv[d] = 1'b0;
        check($sformatf("beats_accepted_dut%0d", d), 65'(k), 65'(n));
    endtask

    task automatic check_reset_state();
        @(posedge clk);
        #1;
        check("rst_tvalid0", 65'(u0_ov), 65'(0)); check("rst_tlast0", 65'(u0_ol), 65'(0));
        check("rst_tdata0", 65'(u0_od), 65'(0)); check("rst_tready0", 65'(u0_ir), 65'(1));
        check("rst_tvalid1", 65'(u1_ov), 65'(0)); check("rst_tdata1", 65'(u1_od), 65'(0));
        check("rst_tready1", 65'(u1_ir), 65'(1));
        check("rst_tvalid2", 65'(u2_ov), 65'(0)); check("rst_tdata2", 65'(u2_od), 65'(0));
        check("rst_tready2", 65'(u2_ir), 65'(1));
    endtask

    initial begin
        logic [15:0] t1[5];
        int s0;
        t1[0] = 16'h0201; t1[1] = 16'h0403; t1[2] = 16'h0605; t1[3] = 16'h0807; t1[4] = 16'h0009;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; idat[d] = '0; stalls[d] = 0; acc[d] = 1'b0;
        end
        model_clear();
        rst_v = 1'b1;
        cycle(); cycle();
        check_reset_state();
        rst_v = 1'b0;

        // single frame 0x01..0x09
        ob0.delete();
        run(0, 9, 0, 8'h01);
        idle(4);
        check("t1_count", 65'(ob0.size()), 65'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < ob0.size()) begin
                check($sformatf("t1_data%0d", i), 65'(ob0[i][15:0]), 65'(t1[i]));
                check($sformatf("t1_last%0d", i), 65'(ob0[i][64]), 65'(i == 4));
            end
        end

        // two frames back to back
        ob0.delete();
        s0 = stalls[0];
        run(0, 18, 0, 8'h11);
        idle(4);
        check("t2_no_input_idle", 65'(stalls[0] - s0), 65'(0));
        check("t2_count", 65'(ob0.size()), 65'(10));
        if (ob0.size() == 10) begin
            check("t2_last5", 65'(ob0[4][64]), 65'(1));
            check("t2_last4", 65'(ob0[3][64]), 65'(0));
            check("t2_last10", 65'(ob0[9][64]), 65'(1));
            check("t2_frame2_lane0", 65'(ob0[5][15:0]), 65'(16'h1b1a));
        end

        // output stall mid-frame
        s0 = stalls[0];
        run(0, 9, 1, 8'h31);
        idle(4);
        check("t3_stall_seen", 65'(stalls[0] > s0), 65'(1));

        // random valid, toggling ready, across several frames
        run(0, 40, 2, 8'h00);
        idle(4);

        // 2-lane-wide beats, short frame with padding
        ob2.delete();
        run(2, 4, 0, 8'h21);
        idle(4);
        check("t6_count", 65'(ob2.size()), 65'(2));
        if (ob2.size() == 2) begin
            check("t6_word1", ob2[0], {1'b0, 64'h232221});
            check("t6_word2", ob2[1], {1'b1, 64'h000024});
        end

        // reset with a held word and three collected beats
        ordy[1] = 1'b0;
        run(1, 7, 4, 8'h50);
        rst_v = 1'b1;
        cycle();
        rst_v = 1'b0;
        @(posedge clk);
        #1;
        check("t5_tvalid_after_reset", 65'(u1_ov), 65'(0));
        check("t5_tready_after_reset", 65'(u1_ir), 65'(1));
        ordy[1] = 1'b1;
        ob1.delete();
        run(1, 4, 0, 8'ha0);
        idle(4);
        check("t5_count", 65'(ob1.size()), 65'(1));
        if (ob1.size() == 1) check("t5_word0", ob1[0], {1'b0, 64'ha3a2a1a0});

        // random traffic on all configurations
        run(1, 30, 3, 8'h00);
        run(2, 30, 3, 8'h00);
        run(0, 30, 3, 8'h00);
        idle(6);
        check("drain_dut0", 65'(qsize(0)), 65'(0));
        check("drain_dut1", 65'(qsize(1)), 65'(0));
        check("drain_dut2", 65'(qsize(2)), 65'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
